extra1_result_collector: RTL and testbench
==========================================

Name: extra1_result_collector

Overview:
- Receive-side companion to the Extra1LP datapath: consumes its 36-bit Q result stream and turns it into a buffered, handshaked result queue.
- The datapath has a fixed pipeline latency and no valid output. This block re-derives result validity from the operand-issue strobe through a latency-matched valid pipeline.
- Valid results are pushed into a show-ahead FIFO that a downstream reader drains with a read-enable handshake.
- Sits directly after Extra1LP. Used for both performance measurement and result readout.

Parameters:
- LATENCY, 3, datapath latency in clock edges from operand sample to valid Q; legal range 1..16.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- WIDTH, 36, result width; must match Q.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  high in the cycle A_in/B_in/C_in hold a new operand triple for the datapath.
- Q_in  input  WIDTH  datapath result.
- rd_en  input  1  reader pops the head entry.
- rd_data  output  WIDTH  head entry (show-ahead).
- rd_valid  output  1  equals !empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  entries held.
- overflow  output  1  sticky; a valid result was dropped.
- res_total  output  16  total results accepted into FIFO; wraps 0xFFFF->0.

Behaviour:
- One clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values: vpipe=0, rd_data=0, rd_valid=0, full=0, empty=1, count=0, overflow=0, res_total=0.
- Reset flushes in-flight valid bits. Results from operands issued before reset are never pushed, even if Q_in later holds them.
- Valid pipeline: vpipe is a LATENCY-bit shift register, vpipe[0] <= in_valid each edge. push = vpipe[LATENCY-1].
- Capture timing: if in_valid is sampled high at edge k, Q_in is captured at edge k+LATENCY.
- Back-to-back: in_valid high on consecutive cycles yields consecutive pushes, one per cycle, in issue order.
- Pop: pop = rd_en && !empty. rd_en while empty is ignored; no state change and no error.
- Push and pop take effect at the same edge.
- Simultaneous push and pop, non-empty: count unchanged; the pushed entry goes to the tail, the head advances.
- Simultaneous push and pop while full: legal, no overflow, count stays DEPTH.
- Push while full without pop: the entry is dropped and overflow is set. overflow clears only on rst; res_total does not increment.
- Push while empty: the entry appears on rd_data with rd_valid=1 in the cycle after the push edge. No same-cycle bypass.
- rd_data shows the head entry whenever rd_valid=1. It holds its last value when empty.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. full/empty are derived from count, not from pointer comparison.
- res_total increments by 1 per accepted push, wrapping modulo 2^16.
- in_valid asserted during rst: ignored; vpipe held 0.

Test Plan:
- Reset: assert rst 2 cycles -> empty=1, count=0, overflow=0, res_total=0, rd_valid=0.
- Latency/order: LATENCY=3; in_valid high for 3 consecutive cycles from edge k. Drive Q_in=10, 2, 7 at edges k+3, k+4, k+5 and 0xFFFFFFFFF otherwise.
  -> count reaches 3 after edge k+5; reads return 10, 2, 7 in order; junk values are never captured.
- Show-ahead: single issue with Q_in=0x123456789 -> rd_valid rises the cycle after the push edge, rd_data=0x123456789. rd_en for 1 cycle -> empty=1, count=0.
- Full/overflow: DEPTH=8; push 9 results with no reads -> full=1, count=8, overflow=1, res_total=8. The 9th value is absent from readout.
- Simultaneous push/pop at full: full FIFO, rd_en=1 on the same cycle a push occurs -> count stays 8, overflow stays 0, the new value is read last.
- Reset mid-flight: issue in_valid, assert rst at edge k+1, release, present Q_in at k+3 -> no push, count=0, res_total=0.

Source files
------------

// File: rtl/extra1_result_collector.sv
// rtl/extra1_result_collector.sv - latency-matched result capture into a show-ahead FIFO
// Re-derives result validity from the issue strobe and buffers accepted results for a reader.
module extra1_result_collector #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         Q_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              res_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        res_total_q, res_total_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               push, pop, accept, is_full;
  logic [AW-1:0]      head_ptr;

  always_comb begin
    vpipe_d[0] = in_valid;
    for (int i = 1; i < LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    push    = vpipe_q[LATENCY-1];
    is_full = (count_q == CW'(DEPTH));
    pop     = rd_en && (count_q != '0);
    // A pop at the same edge frees the slot, so a push into a full FIFO is still accepted.
    accept  = push && (!is_full || pop);

    wr_ptr_d    = wr_ptr_q + AW'(accept);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(accept) - CW'(pop);
    overflow_d  = overflow_q || (push && !accept);
    res_total_d = res_total_q + 16'(accept);

    // Registered head: the new head is the entry being written only when it lands in an emptied FIFO.
    head_ptr  = rd_ptr_d;
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      if (accept && (head_ptr == wr_ptr_q)) begin
        rd_data_d = Q_in;
      end else begin
        rd_data_d = mem_q[head_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      res_total_q <= '0;
    end else begin
      vpipe_q     <= vpipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      res_total_q <= res_total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem_q[wr_ptr_q] <= Q_in;
    end
  end

  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign rd_valid  = (count_q != '0);
  assign overflow  = overflow_q;
  assign res_total = res_total_q;

endmodule

// File: tb/tb_extra1_result_collector.sv
// tb/tb_extra1_result_collector.sv - directed scoreboard bench for extra1_result_collector
// A small datapath model presents Q_in LATENCY edges after each issue; expected results queue at issue time.
module tb_extra1_result_collector;

  localparam int LATENCY = 3;
  localparam int DEPTH   = 8;
  localparam int WIDTH   = 36;
  localparam logic [WIDTH-1:0] JUNK = 36'hFFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] Q_in = JUNK;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, full, empty, overflow;
  logic [3:0]       count;
  logic [15:0]      res_total;

  logic [WIDTH-1:0] sb [$];
  logic             mv [LATENCY];
  logic [WIDTH-1:0] md [LATENCY];
  logic [WIDTH-1:0] iss_data = '0;
  int               total  = 0;
  int               passed = 0;

  extra1_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Q_in(Q_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .res_total(res_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge, then let the datapath model shift and present the next Q_in.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = LATENCY - 1; i > 0; i--) begin
      mv[i] = mv[i-1];
      md[i] = md[i-1];
    end
    mv[0] = in_valid;
    md[0] = iss_data;
    Q_in  = mv[LATENCY-1] ? md[LATENCY-1] : JUNK;
  endtask

  task automatic issue(input logic [WIDTH-1:0] d, input bit expect_push);
    in_valid = 1'b1;
    iss_data = d;
    if (expect_push) sb.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_check();
    logic [WIDTH-1:0] exp;
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    check("rd_valid_at_pop", 64'(rd_valid), 64'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check("rd_data_head", 64'(rd_data), 64'(exp));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LATENCY; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end

    // Reset state
    do_reset();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_res_total", 64'(res_total), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_full", 64'(full), 64'd0);

    // Read while empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_count", 64'(count), 64'd0);
    check("empty_rd_valid", 64'(rd_valid), 64'd0);

    // Latency and ordering with junk outside capture edges
    issue(36'd10, 1'b1);
    issue(36'd2, 1'b1);
    issue(36'd7, 1'b1);
    tick();
    check("lat_count_k3", 64'(count), 64'd1);
    tick();
    check("lat_count_k4", 64'(count), 64'd2);
    tick();
    check("lat_count_k5", 64'(count), 64'd3);
    tick();
    tick();
    check("lat_no_junk", 64'(count), 64'd3);
    check("lat_res_total", 64'(res_total), 64'd3);
    repeat (3) pop_check();
    check("lat_drained", 64'(empty), 64'd1);

    // Show-ahead timing
    issue(36'h123456789, 1'b1);
    tick();
    tick();
    check("sa_before_push", 64'(rd_valid), 64'd0);
    tick();
    check("sa_after_push", 64'(rd_valid), 64'd1);
    pop_check();
    check("sa_empty", 64'(empty), 64'd1);
    check("sa_count", 64'(count), 64'd0);
    check("sa_hold_last", 64'(rd_data), 64'h123456789);

    // Full and overflow: ninth result is dropped
    do_reset();
    for (int i = 0; i < 9; i++) begin
      issue(36'h100 + 36'(i), (i < 8));
    end
    repeat (LATENCY) tick();
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_res_total", 64'(res_total), 64'd8);
    repeat (8) pop_check();
    check("ovf_drained", 64'(empty), 64'd1);
    check("ovf_still_set", 64'(overflow), 64'd1);

    // Simultaneous push and pop while full
    do_reset();
    check("pp_ovf_cleared", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      issue(36'hA00 + 36'(i), 1'b1);
    end
    repeat (LATENCY) tick();
    check("pp_full_before", 64'(full), 64'd1);
    issue(36'h5A5A5A5A5, 1'b1);
    tick();
    tick();
    pop_check();
    check("pp_count", 64'(count), 64'd8);
    check("pp_no_overflow", 64'(overflow), 64'd0);
    check("pp_res_total", 64'(res_total), 64'd9);
    repeat (8) pop_check();
    check("pp_drained", 64'(empty), 64'd1);
    check("pp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-flight flushes in-flight valids; issue during reset is ignored
    issue(36'hABC, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    iss_data = 36'hDEF;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (5) tick();
    check("mid_count", 64'(count), 64'd0);
    check("mid_res_total", 64'(res_total), 64'd0);
    check("mid_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
